voice_sched: RTL and testbench
==============================

Name: voice_sched

Overview:
- Time-multiplexes `voices_p` tone generators onto one mixed sample stream. Generators are square/sine table oscillators with `ready_i`/`data_o`/`valid_o`.
- On each sample-rate tick, scans the voices one per cycle, accumulates their current samples (signed), and pulses each used voice's ready to advance its table address.
- Presents one mixed sample on a valid/ready output toward the DAC/I2S path.
- Sits between the oscillator bank and the audio output serializer.

Parameters:
- width_p, 12, sample width (signed, two's complement), per voice and on output.
- voices_p, 4, number of voices; power of two, at least 2.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- tick_i  input  1  sample-rate strobe, one-cycle pulse.
- enable_i  input  voices_p  per-voice enable mask; bit k = voice k.
- voice_data_i  input  voices_p*width_p  voice k sample at bits [k*width_p +: width_p].
- voice_valid_i  input  voices_p  voice k sample valid.
- voice_ready_o  output  voices_p  one-cycle advance pulse to voice k.
- data_o  output  width_p  mixed sample.
- valid_o  output  1  mixed sample valid.
- ready_i  input  1  downstream accepts `data_o`.
- overrun_o  output  1  sticky: a tick arrived while not IDLE.

Behaviour:
- Reset: FSM=IDLE, accumulator=0, index=0, `voice_ready_o`=0, `valid_o`=0, `data_o`=0, `overrun_o`=0. Reset mid-scan or mid-output aborts immediately; the pending sample is discarded.
- Accumulator width is width_p+$clog2(voices_p), signed; all voice samples are sign-extended.
- IDLE:
  - On `tick_i`=1: clear accumulator, set index=0, go to SCAN.
  - Otherwise stay; all outputs idle except `data_o`, which holds its last value.
- SCAN: one cycle per index k = 0..voices_p-1.
  - If `enable_i[k]` and `voice_valid_i[k]` are both 1: add `voice_data_i[k]` to the accumulator and assert `voice_ready_o[k]` in this same cycle.
  - Otherwise add 0 and keep `voice_ready_o[k]`=0.
  - At most one `voice_ready_o` bit is high in any cycle. Each voice gets at most one pulse per tick.
  - After k = voices_p-1, go to OUT.
- OUT, entry cycle:
  - Register `data_o` = mix(accumulator) and set `valid_o`=1.
  - Latency: tick sampled in cycle t gives SCAN cycles t+1..t+voices_p and `valid_o`=1 from cycle t+voices_p+1.
- OUT, hold: `data_o`/`valid_o` stay stable until `ready_i`=1 while `valid_o`=1. In that cycle the transfer occurs; next cycle `valid_o`=0 and FSM=IDLE.
- `ready_i` is ignored while `valid_o`=0.
- Tick outside IDLE (SCAN or OUT): the tick is dropped and `overrun_o` is set to 1. It clears only on reset.
- Tick in the same cycle as the OUT transfer: counts as an overrun; it is not queued.
- `enable_i` is sampled per index during SCAN. A change mid-scan affects only indices not yet visited.
- All voices disabled or invalid: the output sample is 0 and no ready pulses are issued.
- Default mix (macro undefined): arithmetic shift right of the accumulator by $clog2(voices_p), truncated to width_p. The result is always in range.

Optional Feature:
- Macro: VOICE_SCHED_SAT_EN.
- Defined: mix = accumulator saturated to the signed width_p range, with no shift.
  - Clamp to +(2^(width_p-1)-1) or -(2^(width_p-1)).
  - Maximum loudness; clipping occurs on overflow.
- Undefined: average mode as in Behaviour.

Test Plan:
- Average mode, voices_p=4, all enabled and valid, samples 2047, 2047, 2047, 2047, tick at cycle 10:
  - `voice_ready_o` = 0001, 0010, 0100, 1000 in cycles 11–14.
  - `valid_o`=1 at cycle 15 with `data_o`=2047.
- Average mode, samples 100, -100, 400, 0, `enable_i`=1011:
  - Voice 2 is skipped and gets no ready pulse.
  - `data_o` = (100-100+0)>>>2 = 0.
- Backpressure: hold `ready_i`=0 for 20 cycles after `valid_o`.
  - `data_o` is stable and `valid_o` stays 1.
  - A tick during the stall sets `overrun_o`=1 and produces no second sample.
  - `ready_i`=1 returns the FSM to IDLE the next cycle.
- SAT_EN defined, four voices at 2047:
  - `data_o`=2047, clamped from a sum of 8188.
  - Four voices at -2048 give `data_o`=-2048.
- Assert `reset_i` in the SCAN cycle of index 2:
  - Next cycle: `voice_ready_o`=0, `valid_o`=0, `overrun_o`=0.
  - A subsequent tick restarts at index 0.
- `voice_valid_i`=0000 with all voices enabled, tick:
  - No ready pulses.
  - `valid_o` rises at t+voices_p+1 with `data_o`=0.

Source files
------------

// File: rtl/voice_sched.sv
// Time-multiplexed voice mixer: on each tick scans voices one per cycle, sums their samples and emits one mixed sample.
// Optional macro VOICE_SCHED_SAT_EN selects saturating full-scale mix instead of the averaging shift.
module voice_sched #(
    parameter int width_p  = 12,
    parameter int voices_p = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          tick_i,
    input  logic [voices_p-1:0]           enable_i,
    input  logic [voices_p*width_p-1:0]   voice_data_i,
    input  logic [voices_p-1:0]           voice_valid_i,
    output logic [voices_p-1:0]           voice_ready_o,
    output logic signed [width_p-1:0]     data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          overrun_o
);

    localparam int LOG2 = $clog2(voices_p);
    localparam int AW   = width_p + LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_OUT
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [LOG2-1:0]          r_idx;
    logic signed [AW-1:0]     r_acc;
    logic signed [width_p-1:0] r_data;
    logic                     r_valid;
    logic                     r_overrun;

    logic signed [width_p-1:0] w_sample;
    logic signed [AW-1:0]      w_ext;
    logic signed [AW-1:0]      w_acc_nxt;
    logic                      w_hit;
    logic                      w_last;

`ifdef VOICE_SCHED_SAT_EN
    localparam logic signed [width_p-1:0] OUT_MAX = {1'b0, {(width_p-1){1'b1}}};
    localparam logic signed [width_p-1:0] OUT_MIN = {1'b1, {(width_p-1){1'b0}}};

    function automatic logic signed [width_p-1:0] f_mix(input logic signed [AW-1:0] a);
        if (a > AW'(OUT_MAX))
            return OUT_MAX;
        else if (a < AW'(OUT_MIN))
            return OUT_MIN;
        else
            return width_p'(a);
    endfunction
`else
    // Dividing by the voice count keeps any sum of in-range samples in range.
    function automatic logic signed [width_p-1:0] f_mix(input logic signed [AW-1:0] a);
        return width_p'(a >>> LOG2);
    endfunction
`endif

    assign w_sample  = voice_data_i[r_idx*width_p +: width_p];
    assign w_ext     = AW'(w_sample);
    assign w_hit     = (r_state == S_SCAN) && enable_i[r_idx] && voice_valid_i[r_idx];
    assign w_acc_nxt = r_acc + (w_hit ? w_ext : '0);
    assign w_last    = (r_idx == LOG2'(voices_p - 1));

    assign voice_ready_o = w_hit ? (voices_p'(1) << r_idx) : '0;
    assign data_o        = r_data;
    assign valid_o       = r_valid;
    assign overrun_o     = r_overrun;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (tick_i)  w_next = S_SCAN;
            S_SCAN:  if (w_last)  w_next = S_OUT;
            S_OUT:   if (ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_acc     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_next;
            // Ticks are never queued; any tick outside IDLE is lost and flagged.
            if (tick_i && (r_state != S_IDLE))
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (tick_i) begin
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                S_SCAN: begin
                    r_acc <= w_acc_nxt;
                    r_idx <= r_idx + LOG2'(1);
                    if (w_last) begin
                        r_data  <= f_mix(w_acc_nxt);
                        r_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (ready_i)
                        r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_sched.sv
// Directed table-driven bench for voice_sched (4 voices, 12-bit), covering both mix modes via VOICE_SCHED_SAT_EN.
module tb_voice_sched;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        tick_i;
    logic [3:0]  enable_i;
    logic [47:0] voice_data_i;
    logic [3:0]  voice_valid_i;
    logic [3:0]  voice_ready_o;
    logic signed [11:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        overrun_o;

    int n_pass = 0;
    int n_total = 0;

    voice_sched #(.width_p(12), .voices_p(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i), .enable_i(enable_i),
        .voice_data_i(voice_data_i), .voice_valid_i(voice_valid_i),
        .voice_ready_o(voice_ready_o), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  vld;
        logic [47:0] data;
        logic [3:0]  mask;
        int          exp_avg;
        int          exp_sat;
        logic        rdy_early;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [47:0] pk(input int a, input int b, input int c, input int d);
        return {12'(d), 12'(c), 12'(b), 12'(a)};
    endfunction

    function automatic int expv(input vec_t v);
`ifdef VOICE_SCHED_SAT_EN
        return v.exp_sat;
`else
        return v.exp_avg;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        enable_i      = v.en;
        voice_valid_i = v.vld;
        voice_data_i  = v.data;
        ready_i       = v.rdy_early;
        tick_i        = 1'b1;
        next();
        tick_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("v%0d ready k%0d", id, k), int'(voice_ready_o), int'(v.mask & (4'b1 << k)));
            next();
        end
        #1;
        chk($sformatf("v%0d valid", id), int'(valid_o), 1);
        chk($sformatf("v%0d data", id), int'(data_o), expv(v));
        ready_i = 1'b1;
        next();
        ready_i = 1'b0;
        #1;
        chk($sformatf("v%0d valid drop", id), int'(valid_o), 0);
        chk($sformatf("v%0d data hold", id), int'(data_o), expv(v));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int held;
        vecs[0] = '{4'hF, 4'hF, pk(2047, 2047, 2047, 2047), 4'hF, 2047, 2047, 1'b0};
        vecs[1] = '{4'hB, 4'hF, pk(100, -100, 400, 0),      4'hB, 0,    0,    1'b1};
        vecs[2] = '{4'hF, 4'hF, pk(-2048, -2048, -2048, -2048), 4'hF, -2048, -2048, 1'b0};
        vecs[3] = '{4'hF, 4'h0, pk(5, 6, 7, 8),             4'h0, 0,    0,    1'b1};
        vecs[4] = '{4'hF, 4'hF, pk(1000, 1000, 0, 0),       4'hF, 500,  2000, 1'b0};
        vecs[5] = '{4'h1, 4'hF, pk(-3, 77, 88, 99),         4'h1, -1,   -3,   1'b1};
        vecs[6] = '{4'hF, 4'h6, pk(10, 20, 30, 40),         4'h6, 12,   50,   1'b0};

        reset_i = 1'b1; tick_i = 1'b0; enable_i = '0; voice_data_i = '0;
        voice_valid_i = '0; ready_i = 1'b0;
        repeat (3) next();
        reset_i = 1'b0;
        #1;
        chk("reset ready", int'(voice_ready_o), 0);
        chk("reset valid", int'(valid_o), 0);
        chk("reset data", int'(data_o), 0);
        chk("reset overrun", int'(overrun_o), 0);
        next();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
            next();
        end
        chk("overrun clear after vectors", int'(overrun_o), 0);

        // Backpressure: stall 20 cycles with a tick in the middle.
        enable_i = 4'hF; voice_valid_i = 4'hF; voice_data_i = pk(1000, 1000, 1000, 1000);
        ready_i = 1'b0; tick_i = 1'b1;
        next();
        tick_i = 1'b0;
        repeat (4) next();
        #1;
`ifdef VOICE_SCHED_SAT_EN
        held = 2047;
`else
        held = 1000;
`endif
        chk("bp valid rise", int'(valid_o), 1);
        chk("bp data", int'(data_o), held);
        for (int c = 0; c < 20; c++) begin
            tick_i = (c == 5);
            next();
            tick_i = 1'b0;
            #1;
            chk($sformatf("bp stall valid c%0d", c), int'(valid_o), 1);
            chk($sformatf("bp stall data c%0d", c), int'(data_o), held);
        end
        chk("bp overrun set", int'(overrun_o), 1);
        ready_i = 1'b1;
        next();
        ready_i = 1'b0;
        #1;
        chk("bp valid drop", int'(valid_o), 0);
        repeat (6) next();
        chk("bp no second sample", int'(valid_o), 0);
        chk("bp no ready pulses", int'(voice_ready_o), 0);
        chk("bp overrun sticky", int'(overrun_o), 1);

        // Reset during the index-2 scan cycle.
        voice_data_i = pk(300, 300, 300, 300);
        tick_i = 1'b1;
        next();
        tick_i = 1'b0;
        next();
        next();
        #1;
        chk("rst idx2 ready", int'(voice_ready_o), 4);
        reset_i = 1'b1;
        next();
        reset_i = 1'b0;
        #1;
        chk("rst ready", int'(voice_ready_o), 0);
        chk("rst valid", int'(valid_o), 0);
        chk("rst overrun", int'(overrun_o), 0);
        chk("rst data", int'(data_o), 0);
        repeat (6) next();
        chk("rst sample discarded", int'(valid_o), 0);
        run_vec(vecs[0], 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
